// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - state_t        : FSM state encoding (also exported on the debug port)
//   - ALU_*          : ALUOp encodings driven to the ALU
//   - OP_* / FN_*    : opcode and R-type funct codes recognised by DECODE
//   - FLT_*          : sticky fault codes
//   - PCSRC_* / SRCB_*: PCSource and ALUSrcB mux encodings
//   - is_mem_state() : states that own the shared memory port
//   - funct_aluop()  : R-type funct to ALUOp translation
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_ADDR = 4'd3,
    S_EX_BEQ  = 4'd4,
    S_EX_JRC  = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_WB_ALU  = 4'd8,
    S_WB_MEM  = 4'd9,
    S_FAULT   = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_JRLT = 6'h2c;
  localparam logic [5:0] FN_JRGE = 6'h2d;
  localparam logic [5:0] FN_JRNE = 6'h2e;

  localparam logic [1:0] FLT_NONE    = 2'd0;
  localparam logic [1:0] FLT_ILLEGAL = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_A      = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  function automatic logic is_mem_state(input state_t s);
    return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  endfunction

  function automatic logic [2:0] funct_aluop(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_NOR:  return ALU_NOR;
      FN_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: 8-bit memory wait-state counter with timeout compare.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the count (asserted on every state change)
//   waiting   : memory request outstanding without ready this cycle
//   expired   : count has reached TIMEOUT
// Parameter TIMEOUT: wait limit in cycles, legal range 1..255.
module mc_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)        count_d = '0;
    else if (waiting) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle Moore control FSM for the MIPS datapath.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB over one shared memory port with a
// req/ready handshake, bounded wait states (timeout -> fault 2) and illegal
// instruction detection (fault 1). Faults are sticky until reset.
// Optional feature macro JRCOND_EN: decodes R-type jrlt/jrge/jrne
// (funct 0x2c/0x2d/0x2e) into EX_JRC; when undefined those are illegal.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   opcode, funct       : instruction register fields
//   zero, negative      : ALU flags (same cycle)
//   mem_ready           : memory completes current request
//   mem_req, MemWrite, IorD            : memory port control
//   IRWrite, PCWrite, RegWrite         : register enables
//   ALUSrcA, ALUSrcB, ALUOp, PCSource  : datapath mux / ALU control
//   MemToReg, RegDst    : write-back selects
//   fault               : 0 none, 1 illegal, 2 timeout
//   state               : current state (debug)
module mc_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       negative,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       MemToReg,
  output logic       RegDst,
  output logic [1:0] fault,
  output logic [3:0] state
);

  import mc_pkg::*;

  state_t     state_q, state_d;
  logic [1:0] fault_q, fault_d;
  logic       mem_wait, expired, timer_clear;

  assign mem_wait    = is_mem_state(state_q) && !mem_ready;
  // Any transition clears the counter, which covers entry to every memory
  // state including the back-to-back MEM_WR -> FETCH case.
  assign timer_clear = (state_d != state_q);

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (reset),
    .clear   (timer_clear),
    .waiting (mem_wait),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      fault_q <= FLT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic. In memory states mem_ready takes priority over the
  // timeout so a ready arriving on the limit cycle still completes.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (expired) begin
          state_d = S_FAULT;
          fault_d = FLT_TIMEOUT;
        end
      end
      S_DECODE: begin
        state_d = S_FAULT;
        fault_d = FLT_ILLEGAL;
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_XOR: begin
                state_d = S_EX_R;
                fault_d = fault_q;
              end
`ifdef JRCOND_EN
              FN_JRLT, FN_JRGE, FN_JRNE: begin
                state_d = S_EX_JRC;
                fault_d = fault_q;
              end
`endif
              default: ;
            endcase
          end
          OP_LW, OP_SW: begin
            state_d = S_EX_ADDR;
            fault_d = fault_q;
          end
          OP_BEQ: begin
            state_d = S_EX_BEQ;
            fault_d = fault_q;
          end
          default: ;
        endcase
      end
      S_EX_R:    state_d = S_WB_ALU;
      S_EX_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB_MEM;
        else if (expired) begin
          state_d = S_FAULT;
          fault_d = FLT_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
        else if (expired) begin
          state_d = S_FAULT;
          fault_d = FLT_TIMEOUT;
        end
      end
      S_WB_ALU:  state_d = S_FETCH;
      S_WB_MEM:  state_d = S_FETCH;
      S_EX_BEQ:  state_d = S_FETCH;
`ifdef JRCOND_EN
      S_EX_JRC:  state_d = S_FETCH;
`endif
      S_FAULT:   state_d = S_FAULT;
      default: begin
        state_d = S_FAULT;
        fault_d = FLT_ILLEGAL;
      end
    endcase
  end

`ifndef JRCOND_EN
  logic unused_negative;
  assign unused_negative = negative;
`endif

  // Output decode from registered state; forced low while reset is held.
  always_comb begin
    mem_req  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    ALUOp    = '0;
    PCSource = PCSRC_ALU;
    MemToReg = 1'b0;
    RegDst   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          ALUSrcB  = SRCB_FOUR;
          ALUOp    = ALU_ADD;
          PCSource = PCSRC_ALU;
          IRWrite  = mem_ready;
          PCWrite  = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMM_SH;
          ALUOp   = ALU_ADD;
        end
        S_EX_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = funct_aluop(funct);
        end
        S_EX_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_WB_ALU: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        S_EX_BEQ: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALU_SUB;
          PCSource = PCSRC_ALUOUT;
          PCWrite  = zero;
        end
`ifdef JRCOND_EN
        S_EX_JRC: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALU_SUB;
          PCSource = PCSRC_A;
          case (funct)
            FN_JRLT: PCWrite = negative;
            FN_JRGE: PCWrite = !negative;
            FN_JRNE: PCWrite = !zero;
            default: PCWrite = 1'b0;
          endcase
        end
`endif
        default: ;
      endcase
    end
  end

  assign state = state_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed self-checking bench for mc_control.
// Each instruction is expanded into its expected per-cycle output sequence
// from its class, wait counts and flags; one negedge process compares.
module tb_mc_control;

  localparam int unsigned TO = 15;
`ifdef JRCOND_EN
  localparam bit JRC_ON = 1'b1;
`else
  localparam bit JRC_ON = 1'b0;
`endif

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EX_R = 4'd2,
                         ST_EX_ADDR = 4'd3, ST_EX_BEQ = 4'd4, ST_EX_JRC = 4'd5,
                         ST_MEM_RD = 4'd6, ST_MEM_WR = 4'd7, ST_WB_ALU = 4'd8,
                         ST_WB_MEM = 4'd9, ST_FAULT = 4'd10;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, negative, mem_ready;
  logic       mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, fault;
  logic [2:0] ALUOp;
  logic       MemToReg, RegDst;
  logic [3:0] state;

  mc_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .negative(negative), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .MemToReg(MemToReg), .RegDst(RegDst), .fault(fault),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] flt;
    logic       req, mw, iord, irw, pcw, rw, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       m2r, rdst;
  } obs_t;

  obs_t  act, exp_v, care_v;
  logic  exp_valid = 1'b0;
  int    n_chk = 0, n_fail = 0;
  int    cycles = 0, rw_cnt = 0, mrd_req_cnt = 0;
  string iname = "none", tag = "none";

  assign act = {state, fault, mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, PCSource, MemToReg, RegDst};

  task automatic compare(input string name);
    n_chk++;
    if (((act ^ exp_v) & care_v) != '0) begin
      n_fail++;
      $display("FAIL %s: got state=%0d fault=%0d outs=%h, expected state=%0d fault=%0d outs=%h (care %h)",
               name, act.st, act.flt, act, exp_v.st, exp_v.flt, exp_v, care_v);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      compare({iname, "/", tag});
      if (act.st == ST_MEM_RD && act.req) mrd_req_cnt++;
      if (act.rw) rw_cnt++;
    end
  end

  // Expected record for a state: all enables 0, fault code given, selects
  // unchecked unless a stage sets them.
  task automatic blank(input logic [3:0] st, input logic [1:0] f);
    exp_v = '0; care_v = '0;
    exp_v.st = st; exp_v.flt = f;
    care_v.st = '1; care_v.flt = '1;
    care_v.req = 1'b1; care_v.mw = 1'b1; care_v.irw = 1'b1;
    care_v.pcw = 1'b1; care_v.rw = 1'b1;
  endtask

  task automatic sel(input logic a, input logic [1:0] b, input logic [2:0] op);
    exp_v.srca = a;  care_v.srca = 1'b1;
    exp_v.srcb = b;  care_v.srcb = '1;
    exp_v.aluop = op; care_v.aluop = '1;
  endtask

  task automatic cyc(input logic rdy, input logic z, input logic n, input string name);
    mem_ready = rdy; zero = z; negative = n; tag = name; exp_valid = 1'b1;
    cycles++;
    @(posedge clk); #1;
  endtask

  function automatic logic [2:0] r_aluop(input logic [5:0] f);
    case (f)
      6'h20: return 3'd2;
      6'h22: return 3'd3;
      6'h24: return 3'd4;
      6'h25: return 3'd5;
      6'h27: return 3'd6;
      6'h26: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Memory access: ready arrives after nwait wait cycles; no ready by the
  // (TO+1)-th cycle means timeout. abort_at >= 0 stops early for a reset.
  task automatic mem_phase(input logic [3:0] st, input logic wr, input logic iord,
                           input int nwait, input int abort_at, input string name,
                           output bit ok, output bit aborted);
    logic rdy;
    ok = 1'b0; aborted = 1'b0;
    for (int i = 0; i <= int'(TO); i++) begin
      if (abort_at >= 0 && i == abort_at) begin
        aborted = 1'b1;
        return;
      end
      rdy = (i == nwait);
      blank(st, 2'd0);
      exp_v.req = 1'b1; exp_v.mw = wr;
      exp_v.iord = iord; care_v.iord = 1'b1;
      if (st == ST_FETCH && rdy) begin
        exp_v.irw = 1'b1; exp_v.pcw = 1'b1;
        sel(1'b0, 2'd1, 3'd2);
        exp_v.pcsrc = 2'd0; care_v.pcsrc = '1;
      end
      cyc(rdy, 1'b1, 1'b1, name);
      if (rdy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic fault_hold(input logic [1:0] code);
    for (int i = 0; i < 3; i++) begin
      blank(ST_FAULT, code);
      cyc(1'b1, 1'b1, 1'b1, "fault");
    end
  endtask

  task automatic do_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                          input int fw, input int mw, input logic z, input logic n,
                          input int abort_mem, output int ncyc, output bit faulted,
                          output bit aborted);
    int  c0;
    bit  ok;
    logic is_r, is_jrc, pcw;
    c0 = cycles; faulted = 1'b0; aborted = 1'b0; iname = nm;
    opcode = op; funct = fn;
    is_r   = (op == 6'h00) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27});
    is_jrc = JRC_ON && (op == 6'h00) && (fn inside {6'h2c, 6'h2d, 6'h2e});

    mem_phase(ST_FETCH, 1'b0, 1'b0, fw, -1, "fetch", ok, aborted);
    if (!ok) begin
      fault_hold(2'd2);
      faulted = 1'b1;
      ncyc = cycles - c0;
      return;
    end

    blank(ST_DECODE, 2'd0);
    sel(1'b0, 2'd3, 3'd2);
    cyc(1'b1, 1'b1, 1'b1, "decode");

    if (is_r) begin
      blank(ST_EX_R, 2'd0);
      sel(1'b1, 2'd0, r_aluop(fn));
      cyc(1'b1, 1'b1, 1'b1, "ex_r");
      blank(ST_WB_ALU, 2'd0);
      exp_v.rw = 1'b1;
      exp_v.rdst = 1'b1; care_v.rdst = 1'b1;
      exp_v.m2r = 1'b0;  care_v.m2r = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, "wb_alu");
    end else if (op == 6'h23 || op == 6'h2b) begin
      blank(ST_EX_ADDR, 2'd0);
      sel(1'b1, 2'd2, 3'd2);
      cyc(1'b1, 1'b1, 1'b1, "ex_addr");
      if (op == 6'h23) mem_phase(ST_MEM_RD, 1'b0, 1'b1, mw, abort_mem, "mem_rd", ok, aborted);
      else             mem_phase(ST_MEM_WR, 1'b1, 1'b1, mw, abort_mem, "mem_wr", ok, aborted);
      if (aborted) begin
        ncyc = cycles - c0;
        return;
      end
      if (!ok) begin
        fault_hold(2'd2);
        faulted = 1'b1;
      end else if (op == 6'h23) begin
        blank(ST_WB_MEM, 2'd0);
        exp_v.rw = 1'b1;
        exp_v.rdst = 1'b0; care_v.rdst = 1'b1;
        exp_v.m2r = 1'b1;  care_v.m2r = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, "wb_mem");
      end
    end else if (op == 6'h04) begin
      blank(ST_EX_BEQ, 2'd0);
      sel(1'b1, 2'd0, 3'd3);
      exp_v.pcw = z;
      exp_v.pcsrc = 2'd1; care_v.pcsrc = '1;
      cyc(1'b1, z, n, "ex_beq");
    end else if (is_jrc) begin
      if (fn == 6'h2c)      pcw = n;
      else if (fn == 6'h2d) pcw = !n;
      else                  pcw = !z;
      blank(ST_EX_JRC, 2'd0);
      sel(1'b1, 2'd0, 3'd3);
      exp_v.pcw = pcw;
      exp_v.pcsrc = 2'd2; care_v.pcsrc = '1;
      cyc(1'b1, z, n, "ex_jrc");
    end else begin
      fault_hold(2'd1);
      faulted = 1'b1;
    end
    ncyc = cycles - c0;
  endtask

  // Called at posedge+1; asserts reset mid-cycle, checks outputs drop at once,
  // holds it across one clock edge and releases just after the next edge.
  task automatic do_reset(input string name);
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    iname = name;
    exp_v = '0; care_v = '1;
    compare({name, "/immediate"});
    tag = "hold"; exp_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ncyc;
    bit flt, ab;
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; negative = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    iname = "reset"; exp_v = '0; care_v = '1;
    cyc(1'b1, 1'b1, 1'b1, "hold");
    reset = 1'b0;

    rw_cnt = 0;
    do_instr("add", 6'h00, 6'h20, 0, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    check_int("lat_add", ncyc, 4);
    check_int("regwrite_cycles_add", rw_cnt, 1);
    do_instr("sub", 6'h00, 6'h22, 1, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    do_instr("and", 6'h00, 6'h24, 0, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    do_instr("or",  6'h00, 6'h25, 2, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    do_instr("nor", 6'h00, 6'h27, 0, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    do_instr("xor", 6'h00, 6'h26, 0, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);

    mrd_req_cnt = 0;
    do_instr("lw_wait3", 6'h23, 6'h00, 0, 3, 1'b0, 1'b0, -1, ncyc, flt, ab);
    check_int("lat_lw_wait3", ncyc, 8);
    check_int("memrd_req_cycles", mrd_req_cnt, 4);
    do_instr("sw", 6'h2b, 6'h00, 0, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    check_int("lat_sw", ncyc, 4);
    do_instr("sw_wait", 6'h2b, 6'h00, 2, 2, 1'b0, 1'b0, -1, ncyc, flt, ab);
    check_int("lat_sw_wait", ncyc, 8);

    do_instr("beq_taken", 6'h04, 6'h00, 0, 0, 1'b1, 1'b0, -1, ncyc, flt, ab);
    check_int("lat_beq", ncyc, 3);
    do_instr("beq_not", 6'h04, 6'h00, 0, 0, 1'b0, 1'b1, -1, ncyc, flt, ab);

    do_instr("jrlt", 6'h00, 6'h2c, 0, 0, 1'b0, 1'b1, -1, ncyc, flt, ab);
    if (flt) do_reset("rst_jrlt");
    do_instr("jrge", 6'h00, 6'h2d, 0, 0, 1'b0, 1'b1, -1, ncyc, flt, ab);
    if (flt) do_reset("rst_jrge");
    do_instr("jrne", 6'h00, 6'h2e, 0, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    if (flt) do_reset("rst_jrne");

    do_instr("bad_op", 6'h3f, 6'h00, 0, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    do_reset("rst_bad_op");
    do_instr("bad_funct", 6'h00, 6'h21, 0, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    do_reset("rst_bad_funct");

    do_instr("beq_fetch_limit", 6'h04, 6'h00, 15, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    check_int("lat_beq_fetch_limit", ncyc, 18);
    do_instr("fetch_timeout", 6'h00, 6'h20, 16, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);
    do_reset("rst_fetch_timeout");
    do_instr("lw_timeout", 6'h23, 6'h00, 0, 16, 1'b0, 1'b0, -1, ncyc, flt, ab);
    do_reset("rst_lw_timeout");

    do_instr("sw_abort", 6'h2b, 6'h00, 0, 10, 1'b0, 1'b0, 2, ncyc, flt, ab);
    do_reset("rst_mem_wr");
    do_instr("add_after_reset", 6'h00, 6'h20, 0, 0, 1'b0, 1'b0, -1, ncyc, flt, ab);

    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
